// File: rtl/alu_result_tx.sv
// Serialises an ALU result byte and its four flags as one UART-like frame:
// start, 8 result bits, 4 flag bits, parity, stop (LSB first).
//
// state  | meaning
// IDLE   | line high, ready to accept a word
// START  | start bit (0)
// DATA   | result[0..7]
// FLAGS  | flags[0..3]
// PARITY | parity over the 12 payload bits
// STOP   | stop bit (1)
module alu_result_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] result,
    input  logic [3:0] flags,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_FLAGS,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [7:0] CNT_RELOAD = 8'(CLKS_PER_BIT - 1);
    localparam logic       PAR_INV    = (PARITY_ODD != 0);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [11:0] shift_q, shift_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        bit_end;

    assign bit_end = (cnt_q == 8'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;

        // Down-counter runs in every frame state and reloads at each bit boundary.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? CNT_RELOAD : (cnt_q - 8'd1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (valid && ready_q) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                    cnt_d   = CNT_RELOAD;
                    bit_d   = 3'd0;
                    shift_d = {flags, result};
                    par_d   = (^{flags, result}) ^ PAR_INV;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = S_FLAGS;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_FLAGS: begin
                if (bit_end) begin
                    if (bit_q == 3'd3) begin
                        state_d = S_PARITY;
                        bit_d   = 3'd0;
                        tx_d    = par_q;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= 12'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign ready = ready_q;
    assign tx    = tx_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed + randomized bench: an even- and an odd-parity instance share stimulus,
// and every frame is compared bit period by bit period against a frame model.
module tb_alu_result_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] result = 8'h00;
    logic [3:0] flags = 4'h0;
    logic       valid = 1'b0;
    logic       ready0, tx0, busy0;
    logic       ready1, tx1, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .result(result), .flags(flags),
        .valid(valid), .ready(ready0), .tx(tx0), .busy(busy0)
    );

    alu_result_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .result(result), .flags(flags),
        .valid(valid), .ready(ready1), .tx(tx1), .busy(busy1)
    );

    // Line level for each of the 15 bit periods, index 0 = start bit.
    function automatic logic [14:0] frame_bits(input logic [7:0] r, input logic [3:0] f,
                                               input bit odd);
        logic [14:0] b;
        int ones;
        ones = 0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b[1 + i] = r[i];
            ones += int'(r[i]);
        end
        for (int i = 0; i < 4; i++) begin
            b[9 + i] = f[i];
            ones += int'(f[i]);
        end
        b[13] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        b[14] = 1'b1;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx0"}, 32'(tx0), 32'd1);
        check({tag, "_tx1"}, 32'(tx1), 32'd1);
        check({tag, "_ready"}, 32'(ready0), 32'd1);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin
            step();
            check_idle("idle");
        end
    endtask

    // Present a word while idle; returns at the sample point of the first start-bit cycle.
    task automatic offer(input logic [7:0] r, input logic [3:0] f);
        check("offer_ready", 32'(ready0), 32'd1);
        valid  = 1'b1;
        result = r;
        flags  = f;
        step();
    endtask

    task automatic frame(input logic [7:0] r, input logic [3:0] f, input int stall_k,
                         input bit hold_valid, input logic [7:0] r2, input logic [3:0] f2);
        logic [14:0] exp0, exp1;
        int busy_cnt, exp_len;
        exp0 = frame_bits(r, f, 1'b0);
        exp1 = frame_bits(r, f, 1'b1);
        if (hold_valid) begin
            result = r2;
            flags  = f2;
        end else begin
            valid  = 1'b0;
            result = 8'($urandom);
            flags  = 4'($urandom);
        end
        busy_cnt = 0;
        exp_len  = 15 * CPB + ((stall_k >= 0) ? 7 : 0);
        for (int k = 0; k < 15 * CPB; k++) begin
            check("frame_tx_even", 32'(tx0), 32'(exp0[k / CPB]));
            check("frame_tx_odd", 32'(tx1), 32'(exp1[k / CPB]));
            check("frame_ready", 32'(ready0), 32'd0);
            if (busy0) busy_cnt++;
            if (k == stall_k) begin
                ena = 1'b0;
                repeat (7) begin
                    step();
                    check("stall_tx", 32'(tx0), 32'(exp0[k / CPB]));
                    check("stall_ready", 32'(ready0), 32'd0);
                    if (busy0) busy_cnt++;
                end
                ena = 1'b1;
            end
            step();
        end
        check("end_ready", 32'(ready0), 32'd1);
        check("end_busy", 32'(busy0), 32'd0);
        check("end_tx", 32'(tx0), 32'd1);
        check("busy_len", 32'(busy_cnt), 32'(exp_len));
    endtask

    initial begin
        logic [7:0] rr;
        logic [3:0] ff;
        logic [14:0] expm;

        // Reset held two cycles with valid asserted.
        rst_n  = 1'b0;
        valid  = 1'b1;
        result = 8'h96;
        flags  = 4'h5;
        @(negedge clk);
        repeat (2) begin
            step();
            check_idle("reset");
        end
        rst_n = 1'b1;
        valid = 1'b0;
        idle(3);

        // ena low in idle blocks a transfer.
        ena   = 1'b0;
        valid = 1'b1;
        repeat (3) begin
            step();
            check_idle("ena_low_idle");
        end
        ena   = 1'b1;
        valid = 1'b0;
        idle(1);

        offer(8'hA5, 4'b0100);
        frame(8'hA5, 4'b0100, -1, 1'b0, 8'h00, 4'h0);
        idle(2);

        offer(8'h00, 4'b0001);
        frame(8'h00, 4'b0001, -1, 1'b0, 8'h00, 4'h0);
        idle(1);

        // Back-to-back: valid stays high across the frame boundary.
        offer(8'hFF, 4'b1111);
        frame(8'hFF, 4'b1111, -1, 1'b1, 8'h01, 4'b0000);
        offer(8'h01, 4'b0000);
        frame(8'h01, 4'b0000, -1, 1'b0, 8'h00, 4'h0);
        idle(1);

        // Stall in the middle of data bit 3 (frame bit period 4).
        rr = 8'($urandom);
        ff = 4'($urandom);
        offer(rr, ff);
        frame(rr, ff, 4 * CPB + 1, 1'b0, 8'h00, 4'h0);
        idle(1);

        // Reset during the flags section aborts the frame.
        expm = frame_bits(8'h5A, 4'hB, 1'b0);
        offer(8'h5A, 4'hB);
        valid = 1'b0;
        for (int k = 0; k < 10 * CPB; k++) begin
            check("abort_pre_tx", 32'(tx0), 32'(expm[k / CPB]));
            step();
        end
        rst_n = 1'b0;
        step();
        check_idle("abort_reset");
        rst_n = 1'b1;
        idle(2);
        offer(8'h3C, 4'b0000);
        frame(8'h3C, 4'b0000, -1, 1'b0, 8'h00, 4'h0);

        for (int n = 0; n < 5; n++) begin
            idle(int'($urandom_range(0, 3)) + 1);
            rr = 8'($urandom);
            ff = 4'($urandom);
            offer(rr, ff);
            frame(rr, ff, -1, 1'b0, 8'h00, 4'h0);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
